// File: rtl/cond_status_unit_pkg.sv
// Shared condition-code definitions for the conditional-execution status unit.
// Contents:
//   cond_e          4-bit condition field encodings (EQ .. NV)
//   FLAG_N..FLAG_V  bit positions of N, Z, C, V inside a 4-bit NZCV vector
package cond_defs;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_status_unit_if.sv
// Bus interface for cond_status_unit.
// Ports (master drives, slave receives):
//   stall, flush, flag_we, flag_in[3:0], in_valid[LANES-1:0], cond_in[4*LANES-1:0]
// Returned to the master:
//   out_valid[LANES-1:0], exec_out[LANES-1:0], flags_out[3:0]
interface cond_status_unit_if #(
  parameter int LANES = 2
);

  logic                 stall;
  logic                 flush;
  logic                 flag_we;
  logic [3:0]           flag_in;
  logic [LANES-1:0]     in_valid;
  logic [4*LANES-1:0]   cond_in;
  logic [LANES-1:0]     out_valid;
  logic [LANES-1:0]     exec_out;
  logic [3:0]           flags_out;

  modport master (
    output stall, flush, flag_we, flag_in, in_valid, cond_in,
    input  out_valid, exec_out, flags_out
  );

  modport slave (
    input  stall, flush, flag_we, flag_in, in_valid, cond_in,
    output out_valid, exec_out, flags_out
  );

endinterface

// File: rtl/cond_status_unit_eval.sv
// cond_eval: purely combinational evaluation of one 4-bit condition field
// against an NZCV snapshot.
// Ports:
//   cond_i     condition field
//   nzcv_i     flags {N,Z,C,V}
//   nv_exec_i  result returned for the 4'b1111 encoding
//   true_o     1 when the condition holds
module cond_eval
  import cond_defs::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  input  logic       nv_exec_i,
  output logic       true_o
);

  logic n, z, c, v;

  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  // Decode table of the sixteen condition encodings.
  always_comb begin
    true_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: true_o = z;
      COND_NE: true_o = ~z;
      COND_CS: true_o = c;
      COND_CC: true_o = ~c;
      COND_MI: true_o = n;
      COND_PL: true_o = ~n;
      COND_VS: true_o = v;
      COND_VC: true_o = ~v;
      COND_HI: true_o = c & ~z;
      COND_LS: true_o = ~c | z;
      COND_GE: true_o = (n == v);
      COND_LT: true_o = (n != v);
      COND_GT: true_o = ~z & (n == v);
      COND_LE: true_o = z | (n != v);
      COND_AL: true_o = 1'b1;
      COND_NV: true_o = nv_exec_i;
      default: true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_status_unit.sv
// cond_status_unit: holds the architectural NZCV register and produces a
// registered per-lane execute decision for LANES conditional instructions.
// Parameters:
//   LANES    number of evaluation lanes (1..4)
//   BYPASS   1 = lanes evaluate against a same-cycle flag write
//   NV_EXEC  result for condition code 4'b1111
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of cond_status_unit_if (stall/flush/flag write/lanes in,
//        out_valid/exec_out/flags_out back)
module cond_status_unit
  import cond_defs::*;
#(
  parameter int LANES   = 2,
  parameter int BYPASS  = 1,
  parameter int NV_EXEC = 0
) (
  input  logic              clk,
  input  logic              rst,
  cond_status_unit_if.slave bus
);

  logic [3:0]       flags_q, flags_d;
  logic [LANES-1:0] out_valid_q, out_valid_d;
  logic [LANES-1:0] exec_q, exec_d;
  logic [3:0]       eval_flags;
  logic [LANES-1:0] cond_true;

  // Every lane sees the same snapshot; a retiring flag write is forwarded
  // only when the bypass build option is on.
  assign eval_flags = ((BYPASS != 0) && bus.flag_we) ? bus.flag_in : flags_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cond_eval u_eval (
      .cond_i    (bus.cond_in[4*i +: 4]),
      .nzcv_i    (eval_flags),
      .nv_exec_i (NV_EXEC != 0),
      .true_o    (cond_true[i])
    );
  end

  // Next-state selection. Stall freezes everything (including the flag write,
  // which the producer retries); flush only zeroes the lane results, so a
  // concurrent flag write still commits.
  always_comb begin
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    exec_d      = exec_q;
    if (!bus.stall) begin
      if (bus.flag_we) begin
        flags_d = bus.flag_in;
      end
      if (bus.flush) begin
        out_valid_d = '0;
        exec_d      = '0;
      end else begin
        out_valid_d = bus.in_valid;
        exec_d      = bus.in_valid & cond_true;
      end
    end
  end

  // State registers; reset overrides stall, flush and flag writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= 4'b0000;
      out_valid_q <= '0;
      exec_q      <= '0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      exec_q      <= exec_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.exec_out  = exec_q;
  assign bus.flags_out = flags_q;

endmodule

// File: tb/tb_cond_status_unit.sv
// Self-checking bench for cond_status_unit. Two instances share stimulus:
//   dutA  BYPASS=1, NV_EXEC=0
//   dutB  BYPASS=0, NV_EXEC=1
// A directed vector table covers reset, bypass, signed compares, stall, flush
// and mid-operation reset; a loop then sweeps every code against every NZCV.
module tb_cond_status_unit;

  logic clk;
  logic rst;

  int passCount;
  int totalCount;

  cond_status_unit_if #(.LANES(2)) busA ();
  cond_status_unit_if #(.LANES(2)) busB ();

  cond_status_unit #(.LANES(2), .BYPASS(1), .NV_EXEC(0)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  cond_status_unit #(.LANES(2), .BYPASS(0), .NV_EXEC(1)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       stall;
    logic       flush;
    logic       flagWe;
    logic [3:0] flagIn;
    logic [1:0] inValid;
    logic [7:0] condIn;
    logic [1:0] expValid;
    logic [1:0] expExecA;
    logic [1:0] expExecB;
    logic [3:0] expFlags;
  } vec_t;

  localparam int NUM_VECS = 19;
  vec_t vecs [NUM_VECS];

  function automatic vec_t mk(input logic r, input logic s, input logic f,
                              input logic we, input logic [3:0] fin,
                              input logic [1:0] iv, input logic [7:0] ci,
                              input logic [1:0] ev, input logic [1:0] ea,
                              input logic [1:0] eb, input logic [3:0] ef);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.flagWe = we; t.flagIn = fin;
    t.inValid = iv; t.condIn = ci; t.expValid = ev; t.expExecA = ea;
    t.expExecB = eb; t.expFlags = ef;
    return t;
  endfunction

  // Reference condition table written straight from the encoding list.
  function automatic logic refCond(input logic [3:0] code, input logic [3:0] f,
                                   input logic nv);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return nv;
    endcase
  endfunction

  task automatic applyStimulus(input vec_t t);
    rst           = t.rst;
    busA.stall    = t.stall;   busB.stall    = t.stall;
    busA.flush    = t.flush;   busB.flush    = t.flush;
    busA.flag_we  = t.flagWe;  busB.flag_we  = t.flagWe;
    busA.flag_in  = t.flagIn;  busB.flag_in  = t.flagIn;
    busA.in_valid = t.inValid; busB.in_valid = t.inValid;
    busA.cond_in  = t.condIn;  busB.cond_in  = t.condIn;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    totalCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Advance one active edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    passCount  = 0;
    totalCount = 0;

    //            rst  stl  fl   we   fin      iv     cond    ov     exA    exB    flags
    vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0,4'b0000,2'b00,8'h00, 2'b00,2'b00,2'b00,4'b0000);
    vecs[1]  = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,2'b01,8'h00, 2'b01,2'b00,2'b00,4'b0000);
    vecs[2]  = mk(1'b0,1'b0,1'b0,1'b1,4'b0100,2'b11,8'h10, 2'b11,2'b01,2'b10,4'b0100);
    vecs[3]  = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,2'b01,8'h00, 2'b01,2'b01,2'b01,4'b0100);
    vecs[4]  = mk(1'b0,1'b0,1'b0,1'b1,4'b1001,2'b01,8'h0A, 2'b01,2'b01,2'b01,4'b1001);
    vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,2'b01,8'h0B, 2'b01,2'b00,2'b00,4'b1001);
    vecs[6]  = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,2'b01,8'h0C, 2'b01,2'b01,2'b01,4'b1001);
    vecs[7]  = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,2'b01,8'h0D, 2'b01,2'b00,2'b00,4'b1001);
    vecs[8]  = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,2'b01,8'h0F, 2'b01,2'b00,2'b01,4'b1001);
    vecs[9]  = mk(1'b0,1'b1,1'b0,1'b1,4'b0010,2'b11,8'hEE, 2'b01,2'b00,2'b01,4'b1001);
    vecs[10] = mk(1'b0,1'b1,1'b0,1'b1,4'b0010,2'b11,8'hEE, 2'b01,2'b00,2'b01,4'b1001);
    vecs[11] = mk(1'b0,1'b1,1'b0,1'b1,4'b0010,2'b11,8'hEE, 2'b01,2'b00,2'b01,4'b1001);
    vecs[12] = mk(1'b0,1'b0,1'b1,1'b1,4'b0010,2'b11,8'hEE, 2'b00,2'b00,2'b00,4'b0010);
    vecs[13] = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,2'b11,8'h23, 2'b11,2'b10,2'b10,4'b0010);
    vecs[14] = mk(1'b0,1'b1,1'b1,1'b1,4'b1111,2'b00,8'h00, 2'b11,2'b10,2'b10,4'b0010);
    vecs[15] = mk(1'b1,1'b1,1'b1,1'b1,4'b1111,2'b11,8'hEE, 2'b00,2'b00,2'b00,4'b0000);
    vecs[16] = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,2'b00,8'hEE, 2'b00,2'b00,2'b00,4'b0000);
    vecs[17] = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,2'b10,8'hE0, 2'b10,2'b10,2'b10,4'b0000);
    vecs[18] = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,2'b01,8'hEE, 2'b01,2'b01,2'b01,4'b0000);

    idle = mk(1'b0,1'b0,1'b0,1'b0,4'b0000,2'b00,8'h00, 2'b00,2'b00,2'b00,4'b0000);
    applyStimulus(idle);
    rst = 1'b1;
    #1;

    for (int k = 0; k < NUM_VECS; k++) begin
      applyStimulus(vecs[k]);
      tick();
      checkOutput($sformatf("v%0d out_valid A", k), {6'b0, busA.out_valid}, {6'b0, vecs[k].expValid});
      checkOutput($sformatf("v%0d out_valid B", k), {6'b0, busB.out_valid}, {6'b0, vecs[k].expValid});
      checkOutput($sformatf("v%0d exec A", k), {6'b0, busA.exec_out}, {6'b0, vecs[k].expExecA});
      checkOutput($sformatf("v%0d exec B", k), {6'b0, busB.exec_out}, {6'b0, vecs[k].expExecB});
      checkOutput($sformatf("v%0d flags A", k), {4'b0, busA.flags_out}, {4'b0, vecs[k].expFlags});
      checkOutput($sformatf("v%0d flags B", k), {4'b0, busB.flags_out}, {4'b0, vecs[k].expFlags});
    end

    // Exhaustive sweep: load each NZCV value, then evaluate every code on
    // lane0 and its complement index on lane1 against the registered flags.
    for (int f = 0; f < 16; f++) begin
      vec_t w;
      w = idle;
      w.flagWe = 1'b1;
      w.flagIn = 4'(f);
      applyStimulus(w);
      tick();
      checkOutput($sformatf("sweep load flags %0d A", f), {4'b0, busA.flags_out}, 8'(f));
      checkOutput($sformatf("sweep load flags %0d B", f), {4'b0, busB.flags_out}, 8'(f));
      for (int c = 0; c < 16; c++) begin
        vec_t e;
        logic [3:0] c0, c1;
        logic [1:0] expA, expB;
        c0 = 4'(c);
        c1 = 4'(15 - c);
        e = idle;
        e.inValid = 2'b11;
        e.condIn  = {c1, c0};
        expA = {refCond(c1, 4'(f), 1'b0), refCond(c0, 4'(f), 1'b0)};
        expB = {refCond(c1, 4'(f), 1'b1), refCond(c0, 4'(f), 1'b1)};
        applyStimulus(e);
        tick();
        checkOutput($sformatf("sweep f=%0d c=%0d exec A", f, c), {6'b0, busA.exec_out}, {6'b0, expA});
        checkOutput($sformatf("sweep f=%0d c=%0d exec B", f, c), {6'b0, busB.exec_out}, {6'b0, expB});
      end
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
